// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Multicycle control unit for the MiniMIPS subset. It sequences
//            FETCH/DECODE/EXEC/MEM/WB, drives the 22-bit control word, and
//            produces the PC write enable, instruction-done pulses, and the
//            halt and overflow-trap flags.
// Options  : OVFL_TRAP_EN - overflowing add/sub/addi results are suppressed
//            in WB_ALU and the FSM passes through a one-cycle TRAP state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm #(
  parameter int CTRL_W = 22,
  parameter int ST_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        fn,
  input  logic              alu_zero,
  input  logic              ovfl,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              pc_en,
  output logic              instr_done,
  output logic              halted,
  output logic              ovfl_trap,
  output logic [ST_W-1:0]   state_dbg
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_WB_ALU = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t state, state_nx;
  logic [5:0] op_q, fn_q;
  logic [CTRL_W-1:0] ctrl;

  // The instruction fields are captured as DECODE exits, so EXEC onward
  // decodes from stable copies even if the IR changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= 6'd0;
      fn_q <= 6'd0;
    end else if (state == S_DECODE) begin
      op_q <= op;
      fn_q <= fn;
    end
  end

`ifdef OVFL_TRAP_EN
  logic ovfl_q;
  logic arith_op;
  // Only add, sub, and addi are signed operations that can trap.
  assign arith_op = (state == S_EXEC_R && (fn_q == 6'h20 || fn_q == 6'h22)) ||
                    (state == S_EXEC_I && op_q == 6'h08);

  // The overflow flag is latched in the EXEC cycle and consumed by WB_ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovfl_q <= 1'b0;
    end else if (state == S_EXEC_R || state == S_EXEC_I) begin
      ovfl_q <= ovfl & arith_op;
    end
  end
`else
  logic ovfl_q;
  logic unused_ovfl;
  assign ovfl_q      = 1'b0;
  assign unused_ovfl = ovfl;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Next-state logic and Moore control-word decode.
  always_comb begin
    state_nx   = state;
    ctrl       = '0;
    instr_done = 1'b0;
    halted     = 1'b0;
    ovfl_trap  = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl[11] = 1'b1;            // MEMREAD
        ctrl[10] = 1'b1;            // INSTWRITE
        ctrl[8]  = 1'b1;            // PCWRITE, PC <= PC + 4
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        ctrl[5:4] = 2'b11;          // Z <= PC + (imm << 2), speculative branch target
        case (op)
          6'h00: begin
            case (fn)
              6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
              6'h27, 6'h00, 6'h02, 6'h03: state_nx = S_EXEC_R;
              6'h08:                      state_nx = S_JUMP;
              default:                    state_nx = S_HALT;
            endcase
          end
          6'h08, 6'h0C, 6'h0D, 6'h0E: state_nx = S_EXEC_I;
          6'h23, 6'h2B:               state_nx = S_ADDR;
          6'h04, 6'h05:               state_nx = S_BRANCH;
          6'h02, 6'h03:               state_nx = S_JUMP;
          default:                    state_nx = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ctrl[7:6] = 2'b01;
        ctrl[5:4] = 2'b01;
        case (fn_q)
          6'h22:   ctrl[3:0] = 4'b0100;   // sub
          6'h24:   ctrl[3:0] = 4'b0001;   // and
          6'h25:   ctrl[3:0] = 4'b0101;   // or
          6'h26:   ctrl[3:0] = 4'b1001;   // xor
          6'h27:   ctrl[3:0] = 4'b1101;   // nor
          6'h00:   ctrl[3:0] = 4'b1010;   // sll
          6'h02:   ctrl[3:0] = 4'b0110;   // srl
          6'h03:   ctrl[3:0] = 4'b1110;   // sra
          default: ctrl[3:0] = 4'b0000;   // add
        endcase
        state_nx = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl[7:6] = 2'b01;
        ctrl[5:4] = 2'b10;
        case (op_q)
          6'h0C:   ctrl[3:0] = 4'b0001;   // andi
          6'h0D:   ctrl[3:0] = 4'b0101;   // ori
          6'h0E:   ctrl[3:0] = 4'b1001;   // xori
          default: ctrl[3:0] = 4'b0000;   // addi
        endcase
        state_nx = S_WB_ALU;
      end
      S_WB_ALU: begin
        ctrl[14]    = ~ovfl_q;                          // REGWRITE
        ctrl[18:17] = 2'b01;                            // REGINSRC = Z
        ctrl[16:15] = (op_q == 6'h00) ? 2'b01 : 2'b00;  // rd for R-type, rt otherwise
        if (ovfl_q) begin
          state_nx = S_TRAP;
        end else begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
      end
      S_ADDR: begin
        ctrl[7:6] = 2'b01;
        ctrl[5:4] = 2'b10;
        state_nx  = (op_q == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl[13] = 1'b1;            // IORD
        ctrl[11] = 1'b1;            // MEMREAD
        state_nx = S_WB_MEM;
      end
      S_MEM_WR: begin
        ctrl[13]   = 1'b1;          // IORD
        ctrl[12]   = 1'b1;          // MEMWRITE
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_WB_MEM: begin
        ctrl[14]   = 1'b1;          // REGWRITE, rt <= mem data
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        ctrl[7:6]   = 2'b01;
        ctrl[5:4]   = 2'b01;
        ctrl[3:0]   = 4'b0100;      // subtract to compare rs, rt
        ctrl[9]     = 1'b1;         // PCWRITECOND
        ctrl[20:19] = 2'b01;        // PCSRC = Z (target from DECODE)
        ctrl[21]    = op_q[0];      // bne inverts the zero test
        instr_done  = 1'b1;
        state_nx    = S_FETCH;
      end
      S_JUMP: begin
        ctrl[8]     = 1'b1;
        ctrl[20:19] = (op_q == 6'h00) ? 2'b11 : 2'b10;  // jr takes X
        if (op_q == 6'h03) begin
          ctrl[14]    = 1'b1;       // jal links into $31
          ctrl[16:15] = 2'b10;
          ctrl[18:17] = 2'b10;
        end
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_TRAP: begin
`ifdef OVFL_TRAP_EN
        ovfl_trap = 1'b1;
`endif
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_HALT: begin
        halted   = 1'b1;
        state_nx = S_HALT;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  assign ctrl_out  = ctrl;
  assign state_dbg = state;
  // Only combinational path: branch resolution uses the live zero flag.
  assign pc_en = ctrl[8] | (ctrl[9] & (alu_zero ^ ctrl[21]));

endmodule

`default_nettype wire
